// File: rtl/trees_pkg.sv
// Shared types for the forest-engine feeder: FSM states, command payload, error word.
package trees_pkg;

    localparam int unsigned TRF_NS_W = 16;
    localparam logic [31:0] TRF_ERR_WORD = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_TREE = 3'd1,
        ST_LD_FEAT = 3'd2,
        ST_START   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_EMIT    = 3'd5
    } trf_st_t;

    typedef struct packed {
        logic                load_model;
        logic [TRF_NS_W-1:0] n_samples;
    } trf_cmd_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/trees_load_cnt.sv
// Two-level address counter: low field counts to LO_MAX, then carries into the
// high field; o_last_c flags the enabled step that wraps both fields back to zero.
module trees_load_cnt #(
    parameter int unsigned LO_W   = 8,
    parameter int unsigned HI_W   = 4,
    parameter int unsigned LO_MAX = 255,
    parameter int unsigned HI_MAX = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_en,
    output logic [LO_W-1:0] o_lo,
    output logic [HI_W-1:0] o_hi,
    output logic            o_last_c
);

    logic [LO_W-1:0] r_lo;
    logic [HI_W-1:0] r_hi;
    logic            w_lo_end;
    logic            w_hi_end;

    assign w_lo_end = (r_lo == LO_W'(LO_MAX));
    assign w_hi_end = (r_hi == HI_W'(HI_MAX));
    assign o_last_c = i_en && w_lo_end && w_hi_end;
    assign o_lo     = r_lo;
    assign o_hi     = r_hi;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_lo <= '0;
            r_hi <= '0;
        end else if (i_en) begin
            if (w_lo_end) begin
                r_lo <= '0;
                r_hi <= w_hi_end ? '0 : HI_W'(r_hi + HI_W'(1));
            end else begin
                r_lo <= LO_W'(r_lo + LO_W'(1));
            end
        end
    end

endmodule

// File: rtl/trees_feeder.sv
// Host-side sequencer for the forest inference engine: loads model and features,
// pulses start, returns predictions. Define TRF_TIMEOUT_EN to add the done watchdog.
module trees_feeder
    import trees_pkg::*;
#(
    parameter int unsigned N_TREES          = 16,
    parameter int unsigned N_NODE_AND_LEAFS = 256,
    parameter int unsigned N_FEATURE        = 32,
    parameter int unsigned TIMEOUT_CYCLES   = 4096
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cfg_valid,
    input  logic                                cfg_load_model,
    input  logic [15:0]                         cfg_n_samples,
    output logic                                busy,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [63:0]                         in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [31:0]                         out_data,
    output logic                                load_trees,
    output logic [$clog2(N_NODE_AND_LEAFS)-1:0] n_node,
    output logic [$clog2(N_TREES)-1:0]          n_tree,
    output logic [63:0]                         tree_nodes,
    output logic                                load_features,
    output logic [31:0]                         n_feature,
    output logic [63:0]                         features2,
    output logic                                start,
    input  logic [31:0]                         prediction,
    input  logic                                done,
    output logic                                err
);

    localparam int unsigned NODE_W = $clog2(N_NODE_AND_LEAFS);
    localparam int unsigned TREE_W = $clog2(N_TREES);
    localparam int unsigned PAIRS  = N_FEATURE / 2;
    localparam int unsigned PAIR_W = clog2_min1(PAIRS);

    trf_st_t             r_state;
    logic [TRF_NS_W-1:0] r_samples;
    logic [31:0]         r_out_data;
    trf_cmd_t            w_cmd;
    logic                w_cnt_clr;
    logic                w_tree_hs;
    logic                w_feat_hs;
    logic                w_tree_last_c;
    logic                w_feat_last_c;
    logic                w_feat_lsb;
    logic [PAIR_W-1:0]   w_feat_pair;

    assign w_cmd.load_model = cfg_load_model;
    assign w_cmd.n_samples  = cfg_n_samples;

    assign w_cnt_clr = (r_state == ST_IDLE);
    assign w_tree_hs = in_valid && (r_state == ST_LD_TREE);
    assign w_feat_hs = in_valid && (r_state == ST_LD_FEAT);

    trees_load_cnt #(
        .LO_W   (NODE_W),
        .HI_W   (TREE_W),
        .LO_MAX (N_NODE_AND_LEAFS - 1),
        .HI_MAX (N_TREES - 1)
    ) u_tree_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_cnt_clr),
        .i_en     (w_tree_hs),
        .o_lo     (n_node),
        .o_hi     (n_tree),
        .o_last_c (w_tree_last_c)
    );

    // Low field pinned at zero so the carry counts pairs and {pair, lsb} is the even index.
    trees_load_cnt #(
        .LO_W   (1),
        .HI_W   (PAIR_W),
        .LO_MAX (0),
        .HI_MAX (PAIRS - 1)
    ) u_feat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_cnt_clr),
        .i_en     (w_feat_hs),
        .o_lo     (w_feat_lsb),
        .o_hi     (w_feat_pair),
        .o_last_c (w_feat_last_c)
    );

`ifdef TRF_TIMEOUT_EN
    localparam int unsigned TO_W = clog2_min1(TIMEOUT_CYCLES);
    logic [TO_W-1:0] r_wait_cnt;
    logic            r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
    // Watchdog compiled out; the limit and error word are intentionally unused here.
    if ((TIMEOUT_CYCLES == 0) && (TRF_ERR_WORD == 32'd0)) begin : g_no_watchdog
    end
`endif

    // Sequencer: one command runs optional model load, then per-sample feed/start/wait/emit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_samples  <= '0;
            r_out_data <= '0;
`ifdef TRF_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        r_samples <= w_cmd.n_samples;
                        if (w_cmd.load_model) begin
                            r_state <= ST_LD_TREE;
                        end else if (w_cmd.n_samples != '0) begin
                            r_state <= ST_LD_FEAT;
                        end
                    end
                end
                ST_LD_TREE: begin
                    if (w_tree_last_c) begin
                        r_state <= (r_samples != '0) ? ST_LD_FEAT : ST_IDLE;
                    end
                end
                ST_LD_FEAT: begin
                    if (w_feat_last_c) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    // done is not looked at here: it may still hold the previous result.
                    r_state <= ST_WAIT;
`ifdef TRF_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (done) begin
                        r_out_data <= prediction;
                        r_state    <= ST_EMIT;
                    end
`ifdef TRF_TIMEOUT_EN
                    else if (r_wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_out_data <= TRF_ERR_WORD;
                        r_err      <= 1'b1;
                        r_state    <= ST_EMIT;
                    end else begin
                        r_wait_cnt <= TO_W'(r_wait_cnt + TO_W'(1));
                    end
`endif
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        r_samples <= TRF_NS_W'(r_samples - TRF_NS_W'(1));
                        r_state   <= (r_samples == TRF_NS_W'(1)) ? ST_IDLE : ST_LD_FEAT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign in_ready      = (r_state == ST_LD_TREE) || (r_state == ST_LD_FEAT);
    assign load_trees    = w_tree_hs;
    assign tree_nodes    = w_tree_hs ? in_data : '0;
    assign load_features = w_feat_hs;
    assign features2     = w_feat_hs ? in_data : '0;
    assign n_feature     = 32'({w_feat_pair, w_feat_lsb});
    assign start         = (r_state == ST_START);
    assign out_valid     = (r_state == ST_EMIT);
    assign out_data      = r_out_data;

endmodule

// File: tb/tb_trees_feeder.sv
// Self-checking bench for trees_feeder: directed vector table, randomized command
// runs against a transaction-level reference, reset abort and optional watchdog.
module tb_trees_feeder;

    localparam int unsigned NT = 2;
    localparam int unsigned NN = 4;
    localparam int unsigned NF = 4;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_load_model;
    logic [15:0] cfg_n_samples;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        load_trees;
    logic [1:0]  n_node;
    logic [0:0]  n_tree;
    logic [63:0] tree_nodes;
    logic        load_features;
    logic [31:0] n_feature;
    logic [63:0] features2;
    logic        start;
    logic [31:0] prediction = '0;
    logic        done = 1'b0;
    logic        err;

    trees_feeder #(
        .N_TREES          (NT),
        .N_NODE_AND_LEAFS (NN),
        .N_FEATURE        (NF),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_load_model (cfg_load_model),
        .cfg_n_samples  (cfg_n_samples),
        .busy           (busy),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .load_trees     (load_trees),
        .n_node         (n_node),
        .n_tree         (n_tree),
        .tree_nodes     (tree_nodes),
        .load_features  (load_features),
        .n_feature      (n_feature),
        .features2      (features2),
        .start          (start),
        .prediction     (prediction),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Engine model: start clears done; after eng_lat edges done rises with the next
    // queued prediction and stays high until the following start. eng_lat=0 never answers.
    int          eng_lat = 3;
    int          eng_cnt = 0;
    int          eng_idx = 0;
    logic [31:0] eng_next = '0;
    logic [31:0] eng_preds [64];

    always @(posedge clk) begin
        if (start) begin
            done     <= 1'b0;
            eng_cnt  <= eng_lat;
            eng_next <= eng_preds[eng_idx % 64];
            eng_idx  <= eng_idx + 1;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                done       <= 1'b1;
                prediction <= eng_next;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_pred = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        busy;
        logic        irdy;
        logic        lt;
        logic [0:0]  nt;
        logic [1:0]  nn;
        logic [63:0] tn;
        logic        lf;
        logic [31:0] nf;
        logic [63:0] f2;
        logic        st;
        logic        ov;
        logic [31:0] od;
    } exp_t;

    typedef struct {
        logic        cv;
        logic        cl;
        logic [15:0] cn;
        logic        iv;
        logic [63:0] id;
        logic        ordy;
        exp_t        e;
    } vec_t;

    typedef struct packed {
        logic        lt;
        logic        lf;
        logic [0:0]  nt;
        logic [1:0]  nn;
        logic [31:0] nf;
        logic [63:0] d;
    } wr_t;

    function automatic exp_t obs();
        return '{busy: busy, irdy: in_ready, lt: load_trees, nt: n_tree, nn: n_node,
                 tn: tree_nodes, lf: load_features, nf: n_feature, f2: features2,
                 st: start, ov: out_valid, od: out_data};
    endfunction

    function automatic exp_t ex(input logic b, input logic ir, input logic lt, input int nt,
                                input int nn, input logic [63:0] tn, input logic lf,
                                input int nf, input logic [63:0] f2, input logic st,
                                input logic ov, input logic [31:0] od);
        return '{busy: b, irdy: ir, lt: lt, nt: 1'(nt), nn: 2'(nn), tn: tn, lf: lf,
                 nf: 32'(nf), f2: f2, st: st, ov: ov, od: od};
    endfunction

    function automatic vec_t mk(input logic cv, input logic cl, input int cn, input logic iv,
                                input logic [63:0] id, input logic ordy, input exp_t e);
        return '{cv: cv, cl: cl, cn: 16'(cn), iv: iv, id: id, ordy: ordy, e: e};
    endfunction

    function automatic logic [31:0] fresh_pred();
        logic [31:0] p;
        p = $urandom;
        if (p == last_pred) p = p ^ 32'h1;
        last_pred = p;
        return p;
    endfunction

    // Randomized command against a queue-based reference of writes and predictions.
    task automatic run_cmd(input string tag, input bit lm, input int ns, input int in_pat,
                           input int hold, input int lat);
        logic [63:0] words [$];
        wr_t         exp_wr [$];
        logic [31:0] exp_out [$];
        logic [63:0] d;
        logic [31:0] held;
        wr_t         a;
        int          cyc;
        int          starts;
        int          ov_cnt;
        bit          prev_hold;
        bit          alt;
        if (lm) begin
            for (int i = 0; i < NT * NN; i++) begin
                d = {$urandom, $urandom};
                words.push_back(d);
                exp_wr.push_back('{lt: 1'b1, lf: 1'b0, nt: 1'(i / NN), nn: 2'(i % NN), nf: 32'd0, d: d});
            end
        end
        for (int s = 0; s < ns; s++) begin
            for (int j = 0; j < NF / 2; j++) begin
                d = {$urandom, $urandom};
                words.push_back(d);
                exp_wr.push_back('{lt: 1'b0, lf: 1'b1, nt: 1'b0, nn: 2'd0, nf: 32'(2 * j), d: d});
            end
            eng_preds[(eng_idx + s) % 64] = fresh_pred();
            exp_out.push_back(eng_preds[(eng_idx + s) % 64]);
        end
        eng_lat = lat;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_load_model = lm; cfg_n_samples = 16'(ns);
        in_valid = 1'b0; out_ready = 1'b0;
        #1 check({tag, "_cfg_idle"}, busy, 1'b0);
        cyc = 0; starts = 0; ov_cnt = 0; prev_hold = 0; alt = 0; held = '0;
        while (cyc < 3000) begin
            @(negedge clk);
            // Commands while busy must be ignored.
            cfg_valid = busy && ($urandom_range(0, 7) == 0);
            cfg_load_model = 1'($urandom_range(0, 1));
            cfg_n_samples = 16'($urandom_range(1, 5));
            in_valid = (words.size() != 0) && ((in_pat == 0) ? 1'($urandom_range(0, 1)) : alt);
            alt = !alt;
            in_data = (words.size() != 0) ? words[0] : {$urandom, $urandom};
            out_ready = (ov_cnt >= hold) && ($urandom_range(0, 3) != 0);
            #1;
            check({tag, "_rdy_excl"}, in_ready && out_valid, 1'b0);
            if (in_valid && in_ready) begin
                a = '{lt: load_trees, lf: load_features, nt: n_tree, nn: n_node, nf: n_feature,
                      d: load_trees ? tree_nodes : features2};
                if (exp_wr.size() == 0) begin
                    check({tag, "_extra_write"}, a, '0);
                end else begin
                    check({tag, "_write"}, a, exp_wr.pop_front());
                    void'(words.pop_front());
                end
            end else if (load_trees || load_features) begin
                check({tag, "_spurious_write"}, {load_trees, load_features}, 2'b00);
            end
            if (start) starts++;
            if (out_valid) begin
                if (prev_hold) check({tag, "_hold"}, out_data, held);
                if (out_ready) begin
                    if (exp_out.size() == 0) check({tag, "_extra_pred"}, out_data, '1);
                    else check({tag, "_pred"}, out_data, exp_out.pop_front());
                    ov_cnt = 0;
                end else begin
                    ov_cnt++;
                end
                prev_hold = !out_ready;
                held = out_data;
            end else begin
                prev_hold = 0;
            end
            if (words.size() == 0 && exp_out.size() == 0 && !busy) break;
            cyc++;
        end
        cfg_valid = 1'b0;
        check({tag, "_budget"}, cyc < 3000, 1'b1);
        check({tag, "_starts"}, starts, ns);
        check({tag, "_left"}, exp_wr.size() + exp_out.size(), 0);
    endtask

    vec_t tab [21];

    initial begin
        logic [63:0] w0;
        logic [63:0] w1;
        int          fh;
        int          cyc;
        w0 = 64'h0000_0002_0000_0001;
        w1 = 64'h0000_0004_0000_0003;

        // Model load then one sample with a 3-edge engine returning 5.
        tab[0] = mk(1, 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            tab[1 + i] = mk(0, 0, 0, 1, 64'(32'h10 + i), 0,
                            ex(1, 1, 1, i / 4, i % 4, 64'(32'h10 + i), 0, 0, 0, 0, 0, 0));
        tab[9]  = mk(0, 0, 0, 1, 64'h99, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab[10] = mk(1, 0, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab[11] = mk(0, 0, 0, 1, w0, 0, ex(1, 1, 0, 0, 0, 0, 1, 0, w0, 0, 0, 0));
        tab[12] = mk(0, 0, 0, 1, w1, 0, ex(1, 1, 0, 0, 0, 0, 1, 2, w1, 0, 0, 0));
        tab[13] = mk(0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 14; i < 18; i++)
            tab[i] = mk(0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab[18] = mk(0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
        tab[19] = mk(0, 0, 0, 0, 0, 1, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
        tab[20] = mk(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_load_model = 1'b0; cfg_n_samples = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", obs(), '0);
        check("reset_err", err, 1'b0);
        rst_n = 1'b1;

        eng_lat = 3;
        eng_preds[eng_idx % 64] = 32'd5;
        last_pred = 32'd5;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            cfg_valid = tab[i].cv; cfg_load_model = tab[i].cl; cfg_n_samples = tab[i].cn;
            in_valid = tab[i].iv; in_data = tab[i].id; out_ready = tab[i].ordy;
            #1 check($sformatf("vec%0d", i), obs(), tab[i].e);
        end

        run_cmd("stale", 0, 1, 0, 0, 4);
        run_cmd("bp", 0, 3, 1, 10, 3);
        run_cmd("model", 1, 2, 0, 0, 1);
        run_cmd("noop", 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++)
            run_cmd($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 3), 0, $urandom_range(0, 3), $urandom_range(1, 6));

        // Reset during the second sample's feature load.
        eng_lat = 2;
        for (int s = 0; s < 3; s++) eng_preds[(eng_idx + s) % 64] = fresh_pred();
        w0 = 64'(eng_preds[eng_idx % 64]);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_load_model = 1'b0; cfg_n_samples = 16'd3;
        @(negedge clk);
        cfg_valid = 1'b0;
        fh = 0; cyc = 0;
        while (fh < 3 && cyc < 200) begin
            in_valid = 1'b1; in_data = {$urandom, $urandom}; out_ready = 1'b1;
            #1;
            if (load_features) fh++;
            if (out_valid) check("abort_pred", out_data, w0[31:0]);
            @(negedge clk);
            cyc++;
        end
        check("abort_budget", cyc < 200, 1'b1);
        rst_n = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("abort_outputs", obs(), '0);
        run_cmd("after_abort", 0, 1, 0, 0, 2);

`ifdef TRF_TIMEOUT_EN
        // Engine never answers: error word after TO wait cycles, err sticky.
        eng_lat = 0;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_load_model = 1'b0; cfg_n_samples = 16'd1;
        @(negedge clk);
        cfg_valid = 1'b0; in_valid = 1'b1; in_data = 64'hA;
        @(negedge clk);
        in_data = 64'hB;
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("to_start", start, 1'b1);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            #1 cyc++;
        end
        check("to_wait_cycles", cyc, TO + 1);
        check("to_word", out_data, 32'h8000_0000);
        check("to_err", err, 1'b1);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("to_err_sticky", err, 1'b1);
        check("to_idle", busy, 1'b0);
`else
        check("err_tied", err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
